onewire_xcvr: RTL and testbench
===============================

// Module: onewire_xcvr
// PURPOSE
//   Half-duplex byte transceiver driving one shared open-drain line through an inout port.
//   Sits directly upstream of the pad: the core pushes/pulls bytes via valid/ready, and this block
//   serialises them onto b_line and deserialises traffic from other bus masters.
//   Line framing: start(0), 8 data bits LSB first, [parity], stop(1). External pull-up assumed on board.
// PARAMETERS
//   CLKS_PER_BIT  16  clocks per bit time; legal range >= 4
//   SYNC_STAGES   2   flops in the b_line input synchroniser; legal range >= 2
//   GUARD_BITS    2   bit times the line must be idle-high before TX may start
// PORTS
//   i_clk         input   1  clock
//   i_arst        input   1  asynchronous, active-high reset
//   i_tx_data     input   8  byte to transmit
//   i_tx_valid    input   1  i_tx_data valid
//   o_tx_ready    output  1  transmitter can accept; transfer on i_tx_valid && o_tx_ready
//   o_rx_data     output  8  last received byte; holds until the next frame completes
//   o_rx_valid    output  1  one-cycle pulse: good frame in o_rx_data
//   o_rx_err      output  1  one-cycle pulse: framing/parity error (never with o_rx_valid)
//   o_collision   output  1  one-cycle pulse: TX frame aborted by collision
//   b_line        inout   1  open-drain line: driven 1'b0 or released to 1'bz, never driven 1
// BEHAVIOUR
// - Reset: all outputs 0 (o_rx_data 8'h00). b_line released at once (async, no clock needed).
//   Synchroniser flops reset to 1. FSM -> GUARD; bit counter and idle counter cleared.
// - Drive: b_line = drv_low ? 1'b0 : 1'bz, with drv_low a flop. Sampled line = last sync stage.
// - Bit timer: counts 0..CLKS_PER_BIT-1. Samples are taken at count CLKS_PER_BIT/2 (mid-bit).
// - Idle counter: cleared whenever the sampled line is 0 or the block is transmitting. Saturates
//   at GUARD_BITS*CLKS_PER_BIT while the sampled line is high.
// - FSM: IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP, RX_START, RX_DATA, RX_PAR, RX_STOP, GUARD.
//   - o_tx_ready = (state==IDLE) && idle counter saturated. Registered.
//   - IDLE -> TX_START on accept: load the shift register and set drv_low on the next edge.
//   - IDLE -> RX_START on a sampled 1->0 edge when no TX accept occurs. Accept has priority
//     only if it is in the same cycle; a falling edge with ready=0 goes to RX.
//   - TX_START: drive low for 1 bit time.
//   - TX_DATA: 8 bits, drv_low = ~bit.
//   - TX_STOP: released for 1 bit time -> GUARD.
//   - Collision: in TX_DATA/TX_PAR/TX_STOP, line released but the mid-bit sample is 0.
//     Pulse o_collision, clear drv_low on the same edge, go to GUARD. Byte dropped, no retry.
//   - RX_START: the mid-bit sample must be 0, else return to IDLE silently (glitch reject).
//   - RX_DATA: 8 mid-bit samples shifted in LSB first. RX_STOP: the mid-bit sample must be 1.
//   - RX end, stop bit at mid-bit:
//     - Good: update o_rx_data, pulse o_rx_valid.
//     - Bad (stop=0 or parity mismatch): update o_rx_data, pulse o_rx_err.
//     - Then go to GUARD. There is no RX backpressure.
//   - GUARD -> IDLE when the idle counter saturates. Own TX is never reported on the RX outputs.
// - Latency: accept to b_line low = 1 clock. Line edge to FSM visibility = SYNC_STAGES clocks.
// - Reset mid-frame aborts the frame: no partial o_rx_valid, and after reset the block waits
//   for guard idle before raising o_tx_ready.
// CONFIGURATION
//   ONEWIRE_XCVR_PARITY_EN defined: a TX_PAR/RX_PAR bit (even parity over the 8 data bits) is
//   inserted after the data bits. A mismatch gives o_rx_err; a collision there aborts as above.
//   Undefined: no parity states; frame = 10 bit times.
// TESTING  (CLKS_PER_BIT=16, SYNC_STAGES=2, GUARD_BITS=2, parity off unless stated)
// - Reset release, line pulled up: o_tx_ready rises about 34 clocks later, b_line stays Z.
// - Send 8'hA5: low 16 clks, then bits 1,0,1,0,0,1,0,1 (16 clks each), stop high.
//   o_tx_ready stays 0 until 32 clks of guard have elapsed after the stop bit.
// - Bench drives 8'h3C frame: one o_rx_valid pulse, o_rx_data=8'h3C, o_tx_ready 0 throughout.
// - Send 8'hFF while the bench holds the line low during bit 0: o_collision pulses,
//   b_line is Z on the next clock, and the block returns to IDLE after guard.
// - 4-clock low glitch: no pulse on any output. Frame with stop bit 0: o_rx_err only.
// - ONEWIRE_XCVR_PARITY_EN: send 8'h07 -> parity bit 1. Received 8'h07 with parity 0 -> o_rx_err.
// - Assert i_arst during TX bit 3: b_line is Z immediately and all outputs are 0.

Source files
------------

// File: rtl/onewire_xcvr.sv
// Half-duplex open-drain byte transceiver: start(0), 8 data bits LSB first, [parity], stop(1).
// Define ONEWIRE_XCVR_PARITY_EN to insert an even-parity bit after the data bits.
module onewire_xcvr #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned GUARD_BITS   = 2
) (
    input  logic       i_clk,
    input  logic       i_arst,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_rx_err,
    output logic       o_collision,
    inout  wire        b_line
);

    localparam int unsigned CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDLE_MAX = GUARD_BITS * CLKS_PER_BIT;
    localparam int unsigned IDLE_W   = $clog2(IDLE_MAX + 1);

    localparam logic [CNT_W-1:0]  BIT_MID  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDLE_W-1:0] IDLE_SAT = IDLE_W'(IDLE_MAX);

    typedef enum logic [3:0] {
        IDLE,
        TX_START,
        TX_DATA,
`ifdef ONEWIRE_XCVR_PARITY_EN
        TX_PAR,
`endif
        TX_STOP,
        RX_START,
        RX_DATA,
`ifdef ONEWIRE_XCVR_PARITY_EN
        RX_PAR,
`endif
        RX_STOP,
        GUARD
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     r_line_d;
    logic                     r_drv_low;
    logic [CNT_W-1:0]         r_bit_cnt;
    logic [2:0]               r_bit_idx;
    logic [IDLE_W-1:0]        r_idle_cnt;
    logic [7:0]               r_shift;
    logic                     r_tx_ready;
    logic [7:0]               r_rx_data;
    logic                     r_rx_valid;
    logic                     r_rx_err;
    logic                     r_collision;
`ifdef ONEWIRE_XCVR_PARITY_EN
    logic                     r_tx_par;
    logic                     r_rx_par;
    logic                     w_tx_par_next;
    logic                     w_rx_par_next;
`endif

    logic                     w_line;
    logic                     w_fall;
    logic                     w_mid;
    logic                     w_bit_end;
    logic                     w_accept;
    logic                     w_collide;
    logic                     w_tx_phase;
    logic                     w_drv_next;
    logic [CNT_W-1:0]         w_cnt_next;
    logic [2:0]               w_idx_next;
    logic [IDLE_W-1:0]        w_idle_next;
    logic [7:0]               w_shift_next;
    logic [7:0]               w_rx_data_next;
    logic                     w_rx_valid_next;
    logic                     w_rx_err_next;
    logic                     w_coll_next;
    logic                     w_tx_ready_next;

    assign b_line      = r_drv_low ? 1'b0 : 1'bz;
    assign w_line      = r_sync[SYNC_STAGES-1];
    assign w_fall      = r_line_d & ~w_line;
    assign w_mid       = (r_bit_cnt == BIT_MID);
    assign w_bit_end   = (r_bit_cnt == BIT_LAST);
    assign w_accept    = i_tx_valid & r_tx_ready;
    // A released bit that reads back low means another master is pulling the line.
    assign w_collide   = w_mid & ~r_drv_low & ~w_line;

    assign o_tx_ready  = r_tx_ready;
    assign o_rx_data   = r_rx_data;
    assign o_rx_valid  = r_rx_valid;
    assign o_rx_err    = r_rx_err;
    assign o_collision = r_collision;

    always_comb begin
        w_tx_phase = 1'b0;
        case (r_state)
            TX_START, TX_DATA, TX_STOP: w_tx_phase = 1'b1;
`ifdef ONEWIRE_XCVR_PARITY_EN
            TX_PAR:                     w_tx_phase = 1'b1;
`endif
            default:                    w_tx_phase = 1'b0;
        endcase
    end

    always_comb begin
        w_idle_next = r_idle_cnt;
        if (!w_line || w_tx_phase) begin
            w_idle_next = '0;
        end else if (r_idle_cnt != IDLE_SAT) begin
            w_idle_next = r_idle_cnt + IDLE_W'(1);
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_drv_next      = r_drv_low;
        w_cnt_next      = w_bit_end ? '0 : r_bit_cnt + CNT_W'(1);
        w_idx_next      = r_bit_idx;
        w_shift_next    = r_shift;
        w_rx_data_next  = r_rx_data;
        w_rx_valid_next = 1'b0;
        w_rx_err_next   = 1'b0;
        w_coll_next     = 1'b0;
`ifdef ONEWIRE_XCVR_PARITY_EN
        w_tx_par_next   = r_tx_par;
        w_rx_par_next   = r_rx_par;
`endif
        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (w_accept) begin
                    w_state_next = TX_START;
                    w_drv_next   = 1'b1;
                    w_shift_next = i_tx_data;
`ifdef ONEWIRE_XCVR_PARITY_EN
                    w_tx_par_next = ^i_tx_data;
`endif
                end else if (w_fall) begin
                    w_state_next = RX_START;
                end
            end
            TX_START: begin
                if (w_bit_end) begin
                    w_state_next = TX_DATA;
                    w_idx_next   = '0;
                    w_drv_next   = ~r_shift[0];
                end
            end
            TX_DATA: begin
                if (w_collide) begin
                    w_state_next = GUARD;
                    w_drv_next   = 1'b0;
                    w_coll_next  = 1'b1;
                end else if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
`ifdef ONEWIRE_XCVR_PARITY_EN
                        w_state_next = TX_PAR;
                        w_drv_next   = ~r_tx_par;
`else
                        w_state_next = TX_STOP;
                        w_drv_next   = 1'b0;
`endif
                    end else begin
                        w_idx_next   = r_bit_idx + 3'd1;
                        w_shift_next = {1'b0, r_shift[7:1]};
                        w_drv_next   = ~r_shift[1];
                    end
                end
            end
`ifdef ONEWIRE_XCVR_PARITY_EN
            TX_PAR: begin
                if (w_collide) begin
                    w_state_next = GUARD;
                    w_drv_next   = 1'b0;
                    w_coll_next  = 1'b1;
                end else if (w_bit_end) begin
                    w_state_next = TX_STOP;
                    w_drv_next   = 1'b0;
                end
            end
`endif
            TX_STOP: begin
                if (w_collide) begin
                    w_state_next = GUARD;
                    w_drv_next   = 1'b0;
                    w_coll_next  = 1'b1;
                end else if (w_bit_end) begin
                    w_state_next = GUARD;
                end
            end
            RX_START: begin
                if (w_mid && w_line) begin
                    w_state_next = IDLE;
                end else if (w_bit_end) begin
                    w_state_next = RX_DATA;
                    w_idx_next   = '0;
                end
            end
            RX_DATA: begin
                if (w_mid) begin
                    w_shift_next = {w_line, r_shift[7:1]};
                end
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
`ifdef ONEWIRE_XCVR_PARITY_EN
                        w_state_next = RX_PAR;
`else
                        w_state_next = RX_STOP;
`endif
                    end else begin
                        w_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
`ifdef ONEWIRE_XCVR_PARITY_EN
            RX_PAR: begin
                if (w_mid) begin
                    w_rx_par_next = w_line;
                end
                if (w_bit_end) begin
                    w_state_next = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (w_mid) begin
                    w_state_next   = GUARD;
                    w_rx_data_next = r_shift;
`ifdef ONEWIRE_XCVR_PARITY_EN
                    w_rx_valid_next = w_line & ((^r_shift) == r_rx_par);
`else
                    w_rx_valid_next = w_line;
`endif
                    w_rx_err_next  = ~w_rx_valid_next;
                end
            end
            GUARD: begin
                w_cnt_next = '0;
                if (r_idle_cnt == IDLE_SAT) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = GUARD;
                w_drv_next   = 1'b0;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign w_tx_ready_next = (w_state_next == IDLE) && (w_idle_next == IDLE_SAT);

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state     <= GUARD;
            r_sync      <= '1;
            r_line_d    <= 1'b1;
            r_drv_low   <= 1'b0;
            r_bit_cnt   <= '0;
            r_bit_idx   <= '0;
            r_idle_cnt  <= '0;
            r_shift     <= '0;
            r_tx_ready  <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_rx_err    <= 1'b0;
            r_collision <= 1'b0;
`ifdef ONEWIRE_XCVR_PARITY_EN
            r_tx_par    <= 1'b0;
            r_rx_par    <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_sync      <= {r_sync[SYNC_STAGES-2:0], b_line};
            r_line_d    <= w_line;
            r_drv_low   <= w_drv_next;
            r_bit_cnt   <= w_cnt_next;
            r_bit_idx   <= w_idx_next;
            r_idle_cnt  <= w_idle_next;
            r_shift     <= w_shift_next;
            r_tx_ready  <= w_tx_ready_next;
            r_rx_data   <= w_rx_data_next;
            r_rx_valid  <= w_rx_valid_next;
            r_rx_err    <= w_rx_err_next;
            r_collision <= w_coll_next;
`ifdef ONEWIRE_XCVR_PARITY_EN
            r_tx_par    <= w_tx_par_next;
            r_rx_par    <= w_rx_par_next;
`endif
        end
    end

endmodule

// File: tb/tb_onewire_xcvr.sv
// Directed bench for onewire_xcvr: reset, TX waveform, RX good/bad frames, glitch, collision, async reset.
// Parity scenarios are built when ONEWIRE_XCVR_PARITY_EN is defined.
module tb_onewire_xcvr;

`ifdef ONEWIRE_XCVR_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk       = 1'b0;
    logic       arst      = 1'b1;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_valid  = 1'b0;
    logic       bench_low = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       collision;
    wire        b_line;

    int errors  = 0;
    int checks  = 0;
    int n_valid = 0;
    int n_err   = 0;
    int n_coll  = 0;

    pullup (b_line);
    assign b_line = bench_low ? 1'b0 : 1'bz;

    onewire_xcvr #(
        .CLKS_PER_BIT(16),
        .SYNC_STAGES (2),
        .GUARD_BITS  (2)
    ) dut (
        .i_clk      (clk),
        .i_arst     (arst),
        .i_tx_data  (tx_data),
        .i_tx_valid (tx_valid),
        .o_tx_ready (tx_ready),
        .o_rx_data  (rx_data),
        .o_rx_valid (rx_valid),
        .o_rx_err   (rx_err),
        .o_collision(collision),
        .b_line     (b_line)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid)  n_valid++;
        if (rx_err)    n_err++;
        if (collision) n_coll++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 200; i++) begin
            if (tx_ready) break;
            tick(1);
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: o_tx_ready=%b required 1 within 200 clocks", name, tx_ready);
        end
    endtask

    task automatic test_reset;
        tick(3);
        checks++;
        if ({tx_ready, rx_valid, rx_err, collision} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000", {tx_ready, rx_valid, rx_err, collision});
        end
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_data: got %h required 00", rx_data);
        end
        checks++;
        if (b_line !== 1'b1) begin
            errors++;
            $display("FAIL reset_line: got %b required 1", b_line);
        end
        arst = 1'b0;
        tick(30);
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_guard_early: ready=%b required 0", tx_ready);
        end
        tick(10);
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_guard_done: ready=%b required 1", tx_ready);
        end
        checks++;
        if (b_line !== 1'b1) begin
            errors++;
            $display("FAIL reset_line_idle: got %b required 1", b_line);
        end
    endtask

    task automatic test_tx(input logic [7:0] data);
        int v0;
        int e0;
        logic ready_bad;
        wait_ready("tx_wait_ready");
        v0 = n_valid;
        e0 = n_err;
        ready_bad = 1'b0;
        tx_data  = data;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        checks++;
        if (b_line !== 1'b0) begin
            errors++;
            $display("FAIL tx_start_latency: line=%b required 0", b_line);
        end
        tick(8);
        checks++;
        if (b_line !== 1'b0) begin
            errors++;
            $display("FAIL tx_start_mid: line=%b required 0", b_line);
        end
        for (int i = 0; i < 8; i++) begin
            tick(16);
            if (tx_ready) ready_bad = 1'b1;
            checks++;
            if (b_line !== data[i]) begin
                errors++;
                $display("FAIL tx_bit%0d data %h: line=%b required %b", i, data, b_line, data[i]);
            end
        end
`ifdef ONEWIRE_XCVR_PARITY_EN
        tick(16);
        checks++;
        if (b_line !== ^data) begin
            errors++;
            $display("FAIL tx_parity data %h: line=%b required %b", data, b_line, ^data);
        end
`endif
        tick(16);
        checks++;
        if (b_line !== 1'b1) begin
            errors++;
            $display("FAIL tx_stop: line=%b required 1", b_line);
        end
        tick(36);
        checks++;
        if ((tx_ready | ready_bad) !== 1'b0) begin
            errors++;
            $display("FAIL tx_guard_hold: ready=%b seen_during_frame=%b required 0", tx_ready, ready_bad);
        end
        tick(10);
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL tx_guard_release: ready=%b required 1", tx_ready);
        end
        checks++;
        if ((n_valid - v0) != 0 || (n_err - e0) != 0) begin
            errors++;
            $display("FAIL tx_no_self_rx: valid=%0d err=%0d required 0 0", n_valid - v0, n_err - e0);
        end
    endtask

    // frame holds the line levels LSB first: start, data, [parity], stop
    task automatic test_rx(input string name, input logic [10:0] frame, input logic [7:0] exp_data,
                           input int exp_valid, input int exp_err);
        int v0;
        int e0;
        int c0;
        logic ready_bad;
        wait_ready("rx_wait_ready");
        v0 = n_valid;
        e0 = n_err;
        c0 = n_coll;
        ready_bad = 1'b0;
        for (int i = 0; i < NBITS; i++) begin
            bench_low = ~frame[i];
            tick(8);
            if (tx_ready) ready_bad = 1'b1;
            tick(8);
        end
        bench_low = 1'b0;
        tick(2);
        checks++;
        if ((n_valid - v0) != exp_valid) begin
            errors++;
            $display("FAIL %s_valid: pulses=%0d required %0d", name, n_valid - v0, exp_valid);
        end
        checks++;
        if ((n_err - e0) != exp_err) begin
            errors++;
            $display("FAIL %s_err: pulses=%0d required %0d", name, n_err - e0, exp_err);
        end
        checks++;
        if (rx_data !== exp_data) begin
            errors++;
            $display("FAIL %s_data: got %h required %h", name, rx_data, exp_data);
        end
        checks++;
        if (ready_bad !== 1'b0 || (n_coll - c0) != 0) begin
            errors++;
            $display("FAIL %s_quiet: ready_seen=%b collisions=%0d required 0 0", name, ready_bad, n_coll - c0);
        end
    endtask

    task automatic test_glitch(input logic [7:0] held_data);
        int v0;
        int e0;
        int c0;
        wait_ready("glitch_wait_ready");
        v0 = n_valid;
        e0 = n_err;
        c0 = n_coll;
        bench_low = 1'b1;
        tick(4);
        bench_low = 1'b0;
        tick(40);
        checks++;
        if ((n_valid - v0) != 0 || (n_err - e0) != 0 || (n_coll - c0) != 0) begin
            errors++;
            $display("FAIL glitch_pulses: valid=%0d err=%0d coll=%0d required 0 0 0",
                     n_valid - v0, n_err - e0, n_coll - c0);
        end
        checks++;
        if (rx_data !== held_data) begin
            errors++;
            $display("FAIL glitch_rx_hold: got %h required %h", rx_data, held_data);
        end
    endtask

    task automatic test_collision;
        int v0;
        int e0;
        int c0;
        wait_ready("coll_wait_ready");
        v0 = n_valid;
        e0 = n_err;
        c0 = n_coll;
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(17);
        bench_low = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (collision) break;
        end
        checks++;
        if (collision !== 1'b1) begin
            errors++;
            $display("FAIL coll_pulse: o_collision=%b required 1 within 30 clocks", collision);
        end
        bench_low = 1'b0;
        tick(1);
        checks++;
        if (b_line !== 1'b1) begin
            errors++;
            $display("FAIL coll_release: line=%b required 1", b_line);
        end
        checks++;
        if (collision !== 1'b0) begin
            errors++;
            $display("FAIL coll_one_cycle: o_collision=%b required 0", collision);
        end
        tick(16);
        checks++;
        if (b_line !== 1'b1) begin
            errors++;
            $display("FAIL coll_no_retry: line=%b required 1", b_line);
        end
        wait_ready("coll_return_idle");
        checks++;
        if ((n_coll - c0) != 1 || (n_valid - v0) != 0 || (n_err - e0) != 0) begin
            errors++;
            $display("FAIL coll_counts: coll=%0d valid=%0d err=%0d required 1 0 0",
                     n_coll - c0, n_valid - v0, n_err - e0);
        end
    endtask

    task automatic test_reset_mid_tx;
        int v0;
        wait_ready("rst_wait_ready");
        v0 = n_valid;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(71);
        checks++;
        if (b_line !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre_bit3: line=%b required 0", b_line);
        end
        arst = 1'b1;
        #1;
        checks++;
        if (b_line !== 1'b1) begin
            errors++;
            $display("FAIL rst_async_release: line=%b required 1", b_line);
        end
        checks++;
        if ({tx_ready, rx_valid, rx_err, collision} !== 4'b0000 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_async_outputs: flags=%b data=%h required 0000 00",
                     {tx_ready, rx_valid, rx_err, collision}, rx_data);
        end
        tick(3);
        arst = 1'b0;
        tick(30);
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_guard_early: ready=%b required 0", tx_ready);
        end
        tick(10);
        checks++;
        if (tx_ready !== 1'b1 || (n_valid - v0) != 0) begin
            errors++;
            $display("FAIL rst_guard_done: ready=%b valid_pulses=%0d required 1 0", tx_ready, n_valid - v0);
        end
    endtask

    initial begin
        test_reset();
        test_tx(8'hA5);
`ifdef ONEWIRE_XCVR_PARITY_EN
        test_rx("rx_3c", {1'b1, 1'b0, 8'h3C, 1'b0}, 8'h3C, 1, 0);
        test_glitch(8'h3C);
        test_rx("rx_badstop", {1'b0, 1'b0, 8'h5A, 1'b0}, 8'h5A, 0, 1);
        test_collision();
        test_tx(8'h07);
        test_rx("rx_badpar", {1'b1, 1'b0, 8'h07, 1'b0}, 8'h07, 0, 1);
`else
        test_rx("rx_3c", {1'b0, 1'b1, 8'h3C, 1'b0}, 8'h3C, 1, 0);
        test_glitch(8'h3C);
        test_rx("rx_badstop", {1'b0, 1'b0, 8'h5A, 1'b0}, 8'h5A, 0, 1);
        test_collision();
        test_rx("rx_81", {1'b0, 1'b1, 8'h81, 1'b0}, 8'h81, 1, 0);
`endif
        test_reset_mid_tx();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
